// File: rtl/stage_fetch_buffered_if.sv
// rtl/stage_fetch_buffered_if.sv - imem request/response and IF->ID handshake bundle for stage_fetch_buffered
interface stage_fetch_buffered_if;
    logic        imem_req_valid_o;
    logic        imem_req_ready_i;
    logic [31:0] imem_addr_o;
    logic        imem_rsp_valid_i;
    logic [31:0] imem_rsp_data_i;
    logic        if_valid_o;
    logic        id_ready_i;
    logic [31:0] if_instr_o;
    logic [31:0] if_pc_o;
    logic [31:0] if_pc_plus_four_o;
    logic        if_misalign_o;

    modport master (
        output imem_req_valid_o, imem_addr_o,
        input  imem_req_ready_i, imem_rsp_valid_i, imem_rsp_data_i,
        output if_valid_o, if_instr_o, if_pc_o, if_pc_plus_four_o, if_misalign_o,
        input  id_ready_i
    );

    modport slave (
        input  imem_req_valid_o, imem_addr_o,
        output imem_req_ready_i, imem_rsp_valid_i, imem_rsp_data_i,
        input  if_valid_o, if_instr_o, if_pc_o, if_pc_plus_four_o, if_misalign_o,
        output id_ready_i
    );
endinterface

// File: rtl/stage_fetch_buffered.sv
// rtl/stage_fetch_buffered.sv - decoupled RV32I fetch stage with credit-limited imem fetch and instruction FIFO
// Optional FETCH_MISALIGN_CHK_EN: misaligned redirect targets yield one flagged nop entry instead of a fetch.
module stage_fetch_buffered #(
    parameter logic [31:0] RESET_ADDR      = 32'h0000_0000,
    parameter int          FIFO_DEPTH      = 4,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst_ni,
    input  logic        squash_i,
    input  logic        instr_jal_i,
    input  logic        instr_jalr_i,
    input  logic        branch_taken_i,
    input  logic [31:0] jal_addr_i,
    input  logic [31:0] jalr_addr_i,
    input  logic [31:0] branch_addr_i,
    stage_fetch_buffered_if.master bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    typedef enum logic {S_FETCH, S_FLUSH} state_t;

    state_t        state;
    logic          live_r;
    logic [31:0]   pc_r;
    logic [31:0]   q_instr [FIFO_DEPTH];
    logic [31:0]   q_pc    [FIFO_DEPTH];
    logic [31:0]   q_pc4   [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [OW-1:0] outstanding, drop_cnt, out_next;
    logic [31:0]   tag_pc  [MAX_OUTSTANDING];
    logic [TW-1:0] tag_wr, tag_rd;

    logic        redirect, flush, credit_ok, req_valid, req_fire, rsp;
    logic        push, push_rsp, push_mis, pop, pc_mis;
    logic [31:0] target_raw, target, next_pc, push_instr, push_pc;

    assign redirect   = instr_jalr_i | branch_taken_i | instr_jal_i;
    assign flush      = redirect | squash_i;
    assign target_raw = instr_jalr_i   ? jalr_addr_i   :
                        branch_taken_i ? branch_addr_i : jal_addr_i;
    assign next_pc    = redirect ? target : pc_r;

`ifdef FETCH_MISALIGN_CHK_EN
    logic q_mis [FIFO_DEPTH];
    logic mis_done_r;

    assign target   = target_raw;
    assign pc_mis   = (pc_r[1:0] != 2'b00);
    // No request is ever issued from a misaligned pc, so outstanding==0 here means FLUSH has drained.
    assign push_mis = live_r && !flush && (state == S_FETCH) && pc_mis && !mis_done_r
                      && (outstanding == '0);
    assign bus.if_misalign_o = (count != '0) ? q_mis[rd_ptr] : 1'b0;
`else
    assign target   = target_raw & ~32'h3;
    assign pc_mis   = 1'b0;
    assign push_mis = 1'b0;
    assign bus.if_misalign_o = 1'b0;
`endif

    assign credit_ok = (int'(outstanding) < MAX_OUTSTANDING)
                    && (int'(count) + int'(outstanding) < FIFO_DEPTH);
    assign req_valid = live_r && (state == S_FETCH) && credit_ok && !pc_mis;
    assign req_fire  = req_valid && bus.imem_req_ready_i;
    assign rsp       = bus.imem_rsp_valid_i;
    assign out_next  = outstanding + OW'(req_fire) - OW'(rsp);

    assign push_rsp   = !flush && (state == S_FETCH) && rsp;
    assign push       = push_rsp || push_mis;
    assign pop        = (count != '0) && bus.id_ready_i && !flush;
    assign push_instr = push_mis ? 32'h0000_0013 : bus.imem_rsp_data_i;
    assign push_pc    = push_mis ? pc_r : tag_pc[tag_rd];

    assign bus.imem_req_valid_o  = req_valid;
    assign bus.imem_addr_o       = pc_r;
    assign bus.if_valid_o        = (count != '0);
    assign bus.if_instr_o        = q_instr[rd_ptr];
    assign bus.if_pc_o           = q_pc[rd_ptr];
    assign bus.if_pc_plus_four_o = q_pc4[rd_ptr];

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= S_FETCH;
            live_r      <= 1'b0;
            pc_r        <= RESET_ADDR;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
            tag_wr      <= '0;
            tag_rd      <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                q_instr[i] <= '0;
                q_pc[i]    <= '0;
                q_pc4[i]   <= '0;
            end
            for (int i = 0; i < MAX_OUTSTANDING; i++) tag_pc[i] <= '0;
`ifdef FETCH_MISALIGN_CHK_EN
            for (int i = 0; i < FIFO_DEPTH; i++) q_mis[i] <= 1'b0;
            mis_done_r <= 1'b0;
`endif
        end else begin
            live_r      <= 1'b1;
            outstanding <= out_next;

            // Tags track every accepted request, including ones later dropped, to stay aligned with responses.
            if (req_fire) begin
                tag_pc[tag_wr] <= pc_r;
                tag_wr <= (tag_wr == TW'(MAX_OUTSTANDING - 1)) ? '0 : tag_wr + 1'b1;
            end
            if (rsp) tag_rd <= (tag_rd == TW'(MAX_OUTSTANDING - 1)) ? '0 : tag_rd + 1'b1;

            if (flush) begin
                count    <= '0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                drop_cnt <= out_next;
                pc_r     <= next_pc;
                state    <= (out_next != '0) ? S_FLUSH : S_FETCH;
`ifdef FETCH_MISALIGN_CHK_EN
                mis_done_r <= 1'b0;
`endif
            end else begin
                case (state)
                    S_FETCH: if (req_fire) pc_r <= pc_r + 32'd4;
                    S_FLUSH: if (rsp) begin
                        drop_cnt <= drop_cnt - 1'b1;
                        if (drop_cnt == OW'(1)) state <= S_FETCH;
                    end
                    default: state <= S_FETCH;
                endcase

                if (push) begin
                    q_instr[wr_ptr] <= push_instr;
                    q_pc[wr_ptr]    <= push_pc;
                    q_pc4[wr_ptr]   <= push_pc + 32'd4;
`ifdef FETCH_MISALIGN_CHK_EN
                    q_mis[wr_ptr]   <= push_mis;
`endif
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) rd_ptr <= rd_ptr + 1'b1;
                count <= count + CW'(push) - CW'(pop);
`ifdef FETCH_MISALIGN_CHK_EN
                if (push_mis) mis_done_r <= 1'b1;
`endif
            end
        end
    end
endmodule

// File: tb/tb_stage_fetch_buffered.sv
// tb/tb_stage_fetch_buffered.sv - directed self-checking bench for stage_fetch_buffered
module tb_stage_fetch_buffered;
    logic        clk;
    logic        rst_ni;
    logic        squash_i, instr_jal_i, instr_jalr_i, branch_taken_i;
    logic [31:0] jal_addr_i, jalr_addr_i, branch_addr_i;
    logic        rsp_en;
    int          checks = 0;
    int          errors = 0;
    int          req_cnt;
    logic [31:0] pend [$];

    stage_fetch_buffered_if bus ();

    stage_fetch_buffered dut (
        .clk            (clk),
        .rst_ni         (rst_ni),
        .squash_i       (squash_i),
        .instr_jal_i    (instr_jal_i),
        .instr_jalr_i   (instr_jalr_i),
        .branch_taken_i (branch_taken_i),
        .jal_addr_i     (jal_addr_i),
        .jalr_addr_i    (jalr_addr_i),
        .branch_addr_i  (branch_addr_i),
        .bus            (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    // Memory answers each accepted request one cycle later, in order, while rsp_en is high.
    always @(negedge clk) begin
        if (!rst_ni) begin
            pend.delete();
            req_cnt = 0;
            bus.imem_rsp_valid_i = 1'b0;
            bus.imem_rsp_data_i  = '0;
        end else begin
            if (rsp_en && pend.size() > 0) begin
                bus.imem_rsp_valid_i = 1'b1;
                bus.imem_rsp_data_i  = mem_word(pend.pop_front());
            end else begin
                bus.imem_rsp_valid_i = 1'b0;
                bus.imem_rsp_data_i  = '0;
            end
            if (bus.imem_req_valid_o && bus.imem_req_ready_i) begin
                pend.push_back(bus.imem_addr_o);
                req_cnt++;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic ready, input logic en, input logic idr);
        rst_ni = 1'b0;
        squash_i = 0; instr_jal_i = 0; instr_jalr_i = 0; branch_taken_i = 0;
        jal_addr_i = '0; jalr_addr_i = '0; branch_addr_i = '0;
        bus.imem_req_ready_i = ready;
        bus.id_ready_i = idr;
        rsp_en = en;
        repeat (2) step();
        rst_ni = 1'b1;
    endtask

    task automatic wait_req(input string tag);
        logic ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.imem_req_valid_o) begin ok = 1'b1; break; end
            step();
        end
        chk(tag, {31'b0, ok}, 32'd1);
    endtask

    task automatic wait_valid(input string tag);
        logic ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.if_valid_o) begin ok = 1'b1; break; end
            step();
        end
        chk(tag, {31'b0, ok}, 32'd1);
    endtask

    initial begin
        rst_ni = 1'b1;
        #1;
        do_reset(1'b1, 1'b1, 1'b1);
        rst_ni = 1'b0;
        chk("rst_req_valid", {31'b0, bus.imem_req_valid_o}, 32'd0);
        chk("rst_addr",      bus.imem_addr_o, 32'h0);
        chk("rst_if_valid",  {31'b0, bus.if_valid_o}, 32'd0);
        chk("rst_instr",     bus.if_instr_o, 32'h0);
        chk("rst_pc4",       bus.if_pc_plus_four_o, 32'h0);
        chk("rst_misalign",  {31'b0, bus.if_misalign_o}, 32'd0);

        // Streaming fetch, ID always ready
        do_reset(1'b1, 1'b1, 1'b1);
        wait_valid("t1_wait");
        for (int i = 0; i < 4; i++) begin
            chk("t1_valid", {31'b0, bus.if_valid_o}, 32'd1);
            chk("t1_pc",    bus.if_pc_o, 32'(4 * i));
            chk("t1_instr", bus.if_instr_o, mem_word(32'(4 * i)));
            chk("t1_pc4",   bus.if_pc_plus_four_o, 32'(4 * i + 4));
            chk("t1_addr",  bus.imem_addr_o, 32'(4 * i + 8));
            step();
        end

        // ID stalled: exactly FIFO_DEPTH requests, then drain
        do_reset(1'b1, 1'b1, 1'b0);
        repeat (10) step();
        chk("t2_req_cnt",   32'(req_cnt), 32'd4);
        chk("t2_req_valid", {31'b0, bus.imem_req_valid_o}, 32'd0);
        chk("t2_if_valid",  {31'b0, bus.if_valid_o}, 32'd1);
        chk("t2_hold_pc",   bus.if_pc_o, 32'h0);
        chk("t2_addr",      bus.imem_addr_o, 32'h10);
        bus.id_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t2_drain_valid", {31'b0, bus.if_valid_o}, 32'd1);
            chk("t2_drain_pc",    bus.if_pc_o, 32'(4 * i));
            step();
        end

        // Two in flight at 0x10/0x14, jalr to 0x100 drops both
        do_reset(1'b0, 1'b0, 1'b1);
        wait_req("t3_wait_req");
        instr_jal_i = 1'b1; jal_addr_i = 32'h10;
        step();
        instr_jal_i = 1'b0;
        chk("t3_jal_addr", bus.imem_addr_o, 32'h10);
        bus.imem_req_ready_i = 1'b1;
        step();
        step();
        chk("t3_credit_block", {31'b0, bus.imem_req_valid_o}, 32'd0);
        chk("t3_addr_18",      bus.imem_addr_o, 32'h18);
        instr_jalr_i = 1'b1; jalr_addr_i = 32'h100;
        step();
        instr_jalr_i = 1'b0;
        rsp_en = 1'b1;
        chk("t3_flush1_req", {31'b0, bus.imem_req_valid_o}, 32'd0);
        chk("t3_flush1_addr", bus.imem_addr_o, 32'h100);
        chk("t3_flush1_valid", {31'b0, bus.if_valid_o}, 32'd0);
        step();
        chk("t3_flush2_req", {31'b0, bus.imem_req_valid_o}, 32'd0);
        chk("t3_flush2_valid", {31'b0, bus.if_valid_o}, 32'd0);
        step();
        chk("t3_fetch_req", {31'b0, bus.imem_req_valid_o}, 32'd1);
        chk("t3_fetch_addr", bus.imem_addr_o, 32'h100);
        chk("t3_fetch_valid", {31'b0, bus.if_valid_o}, 32'd0);
        wait_valid("t3_wait_valid");
        chk("t3_pc",    bus.if_pc_o, 32'h100);
        chk("t3_instr", bus.if_instr_o, 32'hC0DE_0100);

        // All redirects at once: jalr wins
        do_reset(1'b1, 1'b1, 1'b1);
        wait_req("t4_wait_req");
        instr_jalr_i = 1'b1; jalr_addr_i = 32'h200;
        branch_taken_i = 1'b1; branch_addr_i = 32'h300;
        instr_jal_i = 1'b1; jal_addr_i = 32'h400;
        step();
        instr_jalr_i = 1'b0; branch_taken_i = 1'b0; instr_jal_i = 1'b0;
        chk("t4_addr",      bus.imem_addr_o, 32'h200);
        chk("t4_flush_req", {31'b0, bus.imem_req_valid_o}, 32'd0);
        step();
        chk("t4_req",       {31'b0, bus.imem_req_valid_o}, 32'd1);
        chk("t4_req_addr",  bus.imem_addr_o, 32'h200);
        wait_valid("t4_wait_valid");
        chk("t4_pc",        bus.if_pc_o, 32'h200);

        // Squash with FIFO full while ID pops
        do_reset(1'b1, 1'b1, 1'b0);
        repeat (10) step();
        chk("t5_full_valid", {31'b0, bus.if_valid_o}, 32'd1);
        chk("t5_full_req",   {31'b0, bus.imem_req_valid_o}, 32'd0);
        squash_i = 1'b1;
        bus.id_ready_i = 1'b1;
        step();
        squash_i = 1'b0;
        chk("t5_empty",      {31'b0, bus.if_valid_o}, 32'd0);
        chk("t5_pc_kept",    bus.imem_addr_o, 32'h10);
        wait_valid("t5_wait_valid");
        chk("t5_pc",         bus.if_pc_o, 32'h10);
        chk("t5_instr",      bus.if_instr_o, 32'hC0DE_0010);

        // PC wraps mod 2^32
        do_reset(1'b0, 1'b1, 1'b0);
        wait_req("t6_wait_req");
        instr_jal_i = 1'b1; jal_addr_i = 32'hFFFF_FFFC;
        step();
        instr_jal_i = 1'b0;
        chk("t6_addr_top", bus.imem_addr_o, 32'hFFFF_FFFC);
        bus.imem_req_ready_i = 1'b1;
        step();
        chk("t6_addr_wrap", bus.imem_addr_o, 32'h0);
        wait_valid("t6_wait_valid");
        chk("t6_pc",    bus.if_pc_o, 32'hFFFF_FFFC);
        chk("t6_pc4",   bus.if_pc_plus_four_o, 32'h0);
        chk("t6_instr", bus.if_instr_o, 32'hC0DE_FFFC);

        // Misaligned branch target
        do_reset(1'b0, 1'b1, 1'b0);
        wait_req("t7_wait_req");
        branch_taken_i = 1'b1; branch_addr_i = 32'h102;
        step();
        branch_taken_i = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
        chk("t7_addr",     bus.imem_addr_o, 32'h102);
        chk("t7_no_req",   {31'b0, bus.imem_req_valid_o}, 32'd0);
        step();
        chk("t7_valid",    {31'b0, bus.if_valid_o}, 32'd1);
        chk("t7_pc",       bus.if_pc_o, 32'h102);
        chk("t7_instr",    bus.if_instr_o, 32'h0000_0013);
        chk("t7_pc4",      bus.if_pc_plus_four_o, 32'h106);
        chk("t7_misalign", {31'b0, bus.if_misalign_o}, 32'd1);
        step();
        chk("t7_stall_req", {31'b0, bus.imem_req_valid_o}, 32'd0);
        chk("t7_req_cnt",   32'(req_cnt), 32'd0);
`else
        chk("t7_addr",     bus.imem_addr_o, 32'h100);
        chk("t7_req",      {31'b0, bus.imem_req_valid_o}, 32'd1);
        bus.imem_req_ready_i = 1'b1;
        wait_valid("t7_wait_valid");
        chk("t7_pc",       bus.if_pc_o, 32'h100);
        chk("t7_misalign", {31'b0, bus.if_misalign_o}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
